// File: rtl/rf_write_arbiter_pkg.sv
// Shared pipeline package for the register-file write arbiter:
// default widths, the x0 address and writeback source encoding.
package rf_write_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int unsigned X0_ADDR = 0;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rf_wr_grant.sv
// Grant decode for the two writeback ports; round-robin pointer by default,
// fixed B priority with an A starvation counter under RF_WR_FIXED_PRIO_EN.
module rf_wr_grant
    import rf_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    logic a_wins;

`ifdef RF_WR_FIXED_PRIO_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1
                                                          : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             starved;

    assign starved = (cnt_q == CNT_W'(STARVE_LIMIT));
    assign a_wins  = starved;

    // Count only cycles where A had a real write pending and lost.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (grant_a_o) begin
                cnt_d = '0;
            end else if (a_req_i && !starved) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic ptr_q;
    logic ptr_d;

    assign a_wins = (ptr_q == SRC_A);

    // Grants are already gated by en_i, so stalls leave the pointer alone.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_a_o) begin
            ptr_d = SRC_B;
        end else if (grant_b_o) begin
            ptr_d = SRC_A;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= SRC_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign grant_a_o = en_i && a_req_i && (!b_req_i || a_wins);
    assign grant_b_o = en_i && b_req_i && (!a_req_i || !a_wins);

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-port register-file writeback arbiter with a registered write port.
// Define RF_WR_FIXED_PRIO_EN for fixed B priority with A starvation guard.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk_In,
    input  logic              Reset_n_In,
    input  logic              A_Valid_In,
    input  logic [ADDR_W-1:0] A_Addr_In,
    input  logic [DATA_W-1:0] A_Data_In,
    output logic              A_Ready_Out,
    input  logic              B_Valid_In,
    input  logic [ADDR_W-1:0] B_Addr_In,
    input  logic [DATA_W-1:0] B_Data_In,
    output logic              B_Ready_Out,
    input  logic              Stall_In,
    output logic              Reg_Write_flag_Out,
    output logic [ADDR_W-1:0] RD_Addr_Out,
    output logic [DATA_W-1:0] RD_Data_Out,
    output logic              Grant_Src_Out
);

    logic en;
    logic a_x0;
    logic b_x0;
    logic a_req;
    logic b_req;
    logic grant_a;
    logic grant_b;

    logic              wr_q;
    logic              wr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              src_q;
    logic              src_d;

    assign en    = Reset_n_In && !Stall_In;
    assign a_x0  = (A_Addr_In == ADDR_W'(X0_ADDR));
    assign b_x0  = (B_Addr_In == ADDR_W'(X0_ADDR));
    assign a_req = A_Valid_In && !a_x0;
    assign b_req = B_Valid_In && !b_x0;

    rf_wr_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk_i    (Clk_In),
        .rst_n_i  (Reset_n_In),
        .en_i     (en),
        .a_req_i  (a_req),
        .b_req_i  (b_req),
        .grant_a_o(grant_a),
        .grant_b_o(grant_b)
    );

    // x0 writes are swallowed on presentation and never contend.
    assign A_Ready_Out = en && A_Valid_In && (a_x0 || grant_a);
    assign B_Ready_Out = en && B_Valid_In && (b_x0 || grant_b);

    always_comb begin
        wr_d   = grant_a || grant_b;
        addr_d = addr_q;
        data_d = data_q;
        src_d  = src_q;
        if (grant_a) begin
            addr_d = A_Addr_In;
            data_d = A_Data_In;
            src_d  = SRC_A;
        end else if (grant_b) begin
            addr_d = B_Addr_In;
            data_d = B_Data_In;
            src_d  = SRC_B;
        end
    end

    always_ff @(posedge Clk_In) begin
        if (!Reset_n_In) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            src_q  <= SRC_A;
        end else begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            src_q  <= src_d;
        end
    end

    assign Reg_Write_flag_Out = wr_q;
    assign RD_Addr_Out        = addr_q;
    assign RD_Data_Out        = data_q;
    assign Grant_Src_Out      = src_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_v;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_rdy;
    logic        b_v;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_rdy;
    logic        stall;
    logic        wr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DATA_W(32),
        .ADDR_W(5),
        .STARVE_LIMIT(4)
    ) dut (
        .Clk_In            (clk),
        .Reset_n_In        (rst_n),
        .A_Valid_In        (a_v),
        .A_Addr_In         (a_addr),
        .A_Data_In         (a_data),
        .A_Ready_Out       (a_rdy),
        .B_Valid_In        (b_v),
        .B_Addr_In         (b_addr),
        .B_Data_In         (b_data),
        .B_Ready_Out       (b_rdy),
        .Stall_In          (stall),
        .Reg_Write_flag_Out(wr),
        .RD_Addr_Out       (rd_addr),
        .RD_Data_Out       (rd_data),
        .Grant_Src_Out     (src)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_v = 1'b0;
        b_v = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_v = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b required 00", {a_rdy, b_rdy});
        end
        tick();
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_out: got %b %0d %h %b required 0 0 0 0",
                     wr, rd_addr, rd_data, src);
        end
        a_v = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        a_v = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b required 10", {a_rdy, b_rdy});
        end
        tick();
        a_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd3, 32'h11, 1'b0}) begin
            errors++;
            $display("FAIL single_write: got %b %0d %h %b required 1 3 11 0",
                     wr, rd_addr, rd_data, src);
        end
        tick();
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b0, 5'd3, 32'h11, 1'b0}) begin
            errors++;
            $display("FAIL single_hold: got %b %0d %h %b required 0 3 11 0",
                     wr, rd_addr, rd_data, src);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        a_v = 1'b1; a_addr = 5'd5; a_data = 32'hAA;
        b_v = 1'b1; b_addr = 5'd6; b_data = 32'hBB;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b10) begin
            errors++;
            $display("FAIL rr_ready1: got %b required 10", {a_rdy, b_rdy});
        end
        tick();
        a_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd5, 32'hAA, 1'b0}) begin
            errors++;
            $display("FAIL rr_cyc1: got %b %0d %h %b required 1 5 aa 0",
                     wr, rd_addr, rd_data, src);
        end
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b01) begin
            errors++;
            $display("FAIL rr_ready2: got %b required 01", {a_rdy, b_rdy});
        end
        tick();
        b_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd6, 32'hBB, 1'b1}) begin
            errors++;
            $display("FAIL rr_cyc2: got %b %0d %h %b required 1 6 bb 1",
                     wr, rd_addr, rd_data, src);
        end
        tick();
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b0, 5'd6, 32'hBB, 1'b1}) begin
            errors++;
            $display("FAIL rr_cyc3: got %b %0d %h %b required 0 6 bb 1",
                     wr, rd_addr, rd_data, src);
        end
    endtask

    task automatic test_x0();
        a_v = 1'b1; a_addr = 5'd0; a_data = 32'hFF;
        b_v = 1'b1; b_addr = 5'd7; b_data = 32'h22;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL x0_ready: got %b required 11", {a_rdy, b_rdy});
        end
        tick();
        a_v = 1'b0;
        b_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd7, 32'h22, 1'b1}) begin
            errors++;
            $display("FAIL x0_write: got %b %0d %h %b required 1 7 22 1",
                     wr, rd_addr, rd_data, src);
        end
        tick();
        checks++;
        if (wr !== 1'b0) begin
            errors++;
            $display("FAIL x0_single: got flag %b required 0", wr);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        a_v = 1'b1; a_addr = 5'd4; a_data = 32'h1;
        b_v = 1'b1; b_addr = 5'd0; b_data = 32'h5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({a_rdy, b_rdy} !== 2'b00) begin
                errors++;
                $display("FAIL stall_ready%0d: got %b required 00", i, {a_rdy, b_rdy});
            end
            tick();
            checks++;
            if (wr !== 1'b0) begin
                errors++;
                $display("FAIL stall_flag%0d: got %b required 0", i, wr);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL stall_release: got %b required 11", {a_rdy, b_rdy});
        end
        tick();
        a_v = 1'b0;
        b_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd4, 32'h1, 1'b0}) begin
            errors++;
            $display("FAIL stall_write: got %b %0d %h %b required 1 4 1 0",
                     wr, rd_addr, rd_data, src);
        end
    endtask

    // Pointer sits at B here: B goes first, then A, same address twice.
    task automatic test_same_addr();
        a_v = 1'b1; a_addr = 5'd12; a_data = 32'hA1;
        b_v = 1'b1; b_addr = 5'd12; b_data = 32'hB2;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b01) begin
            errors++;
            $display("FAIL same_ready: got %b required 01", {a_rdy, b_rdy});
        end
        tick();
        b_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd12, 32'hB2, 1'b1}) begin
            errors++;
            $display("FAIL same_first: got %b %0d %h %b required 1 12 b2 1",
                     wr, rd_addr, rd_data, src);
        end
        tick();
        a_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd12, 32'hA1, 1'b0}) begin
            errors++;
            $display("FAIL same_second: got %b %0d %h %b required 1 12 a1 0",
                     wr, rd_addr, rd_data, src);
        end
    endtask

    // Pointer sits at B before reset; reset must return priority to A.
    task automatic test_reset_contention();
        a_v = 1'b1; a_addr = 5'd13; a_data = 32'h31;
        b_v = 1'b1; b_addr = 5'd14; b_data = 32'h42;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL rstc_ready: got %b required 00", {a_rdy, b_rdy});
        end
        tick();
        rst_n = 1'b1;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL rstc_out: got %b %0d %h %b required 0 0 0 0",
                     wr, rd_addr, rd_data, src);
        end
        tick();
        a_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd13, 32'h31, 1'b0}) begin
            errors++;
            $display("FAIL rstc_first: got %b %0d %h %b required 1 13 31 0",
                     wr, rd_addr, rd_data, src);
        end
        tick();
        b_v = 1'b0;
        checks++;
        if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd14, 32'h42, 1'b1}) begin
            errors++;
            $display("FAIL rstc_second: got %b %0d %h %b required 1 14 42 1",
                     wr, rd_addr, rd_data, src);
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        a_v = 1'b1; a_addr = 5'd9; a_data = 32'h9;
        b_v = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            b_addr = 5'(15 + i);
            b_data = 32'(32'h100 + i);
            #1;
            checks++;
            if ({a_rdy, b_rdy} !== ((i == 5) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL fixed_ready%0d: got %b", i, {a_rdy, b_rdy});
            end
            tick();
            if (i == 5) begin
                a_v = 1'b0;
                checks++;
                if ({wr, rd_addr, rd_data, src} !== {1'b1, 5'd9, 32'h9, 1'b0}) begin
                    errors++;
                    $display("FAIL fixed_a: got %b %0d %h %b required 1 9 9 0",
                             wr, rd_addr, rd_data, src);
                end
            end else begin
                checks++;
                if ({wr, rd_addr, src} !== {1'b1, 5'(15 + i), 1'b1}) begin
                    errors++;
                    $display("FAIL fixed_b%0d: got %b %0d %b required 1 %0d 1",
                             i, wr, rd_addr, src, 15 + i);
                end
            end
        end
        b_v = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_v = 1'b0; a_addr = '0; a_data = '0;
        b_v = 1'b0; b_addr = '0; b_data = '0;
        stall = 1'b0;
        tick();
        test_reset();
        test_single();
`ifdef RF_WR_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
        test_x0();
        test_stall();
        test_same_addr();
        test_reset_contention();
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of write data.
REQ-002 Parameter ADDR_W, default 5: width of register address.
REQ-003 Parameter STARVE_LIMIT, default 4: maximum consecutive lost cycles for port A in fixed-priority mode.
REQ-004 Clk_In  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Reset_n_In  input  1  synchronous, active-low reset.
REQ-006 A_Valid_In / A_Addr_In / A_Data_In  input  1 / ADDR_W / DATA_W  ALU writeback request.
REQ-007 A_Ready_Out  output  1  accept for port A.
REQ-008 B_Valid_In / B_Addr_In / B_Data_In  input  1 / ADDR_W / DATA_W  load-unit writeback request.
REQ-009 B_Ready_Out  output  1  accept for port B.
REQ-010 Stall_In  input  1  register-file write port unavailable.
REQ-011 Reg_Write_flag_Out / RD_Addr_Out / RD_Data_Out  output  1 / ADDR_W / DATA_W  registered register-file write port.
REQ-012 Grant_Src_Out  output  1  source of the current write (0 = A, 1 = B).

Function
REQ-013 A transfer SHALL occur when Valid and Ready are both high in the same cycle; Valid and payload SHALL be held by the requester until the transfer occurs.
REQ-014 Ready SHALL be combinational from Valid, Addr, Stall_In and arbitration state; it SHALL NOT depend on Ready.
REQ-015 A request with Addr = 0 SHALL be accepted in the cycle it is presented, without contending, and SHALL produce no write (x0 is hardwired zero).
REQ-016 At most one nonzero-address request SHALL be granted per cycle.
REQ-017 The granted request SHALL appear on the output registers at the next edge, with Reg_Write_flag_Out high for exactly one cycle (1-cycle latency).
REQ-018 When no nonzero request is granted, Reg_Write_flag_Out SHALL be 0, and RD_Addr_Out, RD_Data_Out and Grant_Src_Out SHALL hold their previous values.
REQ-019 Default policy is round-robin: one pointer bit; after any nonzero grant the pointer SHALL point at the other port; it SHALL hold otherwise.
REQ-020 On contention, the port named by the pointer SHALL win; an uncontended valid nonzero request SHALL always win.
REQ-021 Same-address contention SHALL NOT be coalesced; the two writes SHALL issue in grant order on consecutive grants.
REQ-022 While Stall_In is 1, both Ready outputs SHALL be 0 (including x0 requests), no write SHALL issue next cycle, and the pointer and starvation counter SHALL hold.

Reset
REQ-023 While Reset_n_In is 0 at an edge, Reg_Write_flag_Out, RD_Addr_Out, RD_Data_Out and Grant_Src_Out SHALL become 0, the pointer SHALL select A, and the starvation counter SHALL become 0.
REQ-024 While Reset_n_In is 0, both Ready outputs SHALL be 0; requests pending across reset SHALL NOT be accepted and SHALL be re-presented by the requester.

Configuration
REQ-025 When macro RF_WR_FIXED_PRIO_EN is defined, B SHALL win contention, subject to the starvation counter.
REQ-026 With RF_WR_FIXED_PRIO_EN defined: the counter SHALL increment on each non-stalled cycle in which A is valid with a nonzero address and not granted; when it equals STARVE_LIMIT, A SHALL win the next contention, and the counter SHALL clear on any A grant.
REQ-027 With RF_WR_FIXED_PRIO_EN undefined, round-robin per REQ-019/020 SHALL apply and no counter SHALL exist.

Structure
REQ-028 DATA_W/ADDR_W defaults, the x0 address constant and the source encoding (SRC_A = 0, SRC_B = 1) SHALL reside in the shared pipeline package.
REQ-029 The grant logic SHALL be one sub-module, rf_wr_grant (pointer/counter plus grant decode); the output register SHALL be in the top module.

Verification
REQ-030 Reset, then A(addr 3, data 0x11) alone -> A_Ready=1 the same cycle; next cycle flag=1, RD_Addr=3, RD_Data=0x11, Grant_Src=0.
REQ-031 A(5, 0xAA) and B(6, 0xBB) held valid from reset, round-robin -> A written in cycle 1 and B in cycle 2; flag low in cycle 3.
REQ-032 A(0, 0xFF) and B(7, 0x22) in the same cycle -> both Ready=1; next cycle a single write of addr 7, data 0x22.
REQ-033 Stall_In=1 for 3 cycles with A(4, 0x1) valid -> A_Ready=0 and flag=0 throughout; A is written the cycle after Stall_In falls.
REQ-034 RF_WR_FIXED_PRIO_EN, STARVE_LIMIT=4, B continuously valid (nonzero) and A(9, 0x9) valid -> A granted on the 5th contended cycle, B on the others.
REQ-035 Reset_n_In=0 for one cycle while A and B are contending -> no Ready that cycle, outputs zero next cycle, and A granted first after release.
